microwave_timer: RTL and testbench

- Parametrised successor to the microwave countdown controller: on/idle/run/pause/done FSM, preset table, ±step editing, door interlock, auto power-off, end-of-cycle beep, turntable phase.
- Internally prescales the board clock to a 1 s tick.
- Drives the BCD/7-seg display path (time_left), the lamp/heater/motor LEDs and the sound mux enable.
- Replaces the hard-coded 9-bit/4-preset logic.

---
 rtl/microwave_pkg.sv | 32 +++
 rtl/mw_tick_gen.sv | 29 ++
 rtl/microwave_timer.sv | 212 +++++++++++++++++++++
 tb/tb_microwave_timer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: state encoding, heater duty table and default presets
// shared by the microwave_timer controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DUTY_WIN = 10;

  // Index 0 sits in the LSBs.
  localparam logic [35:0] DEF_PRESETS =
    {9'd300, 9'd100, 9'd110, 9'd90};

  function automatic logic [3:0] duty_ticks(
    input logic [1:0] lvl
  );
    logic [3:0] n;
    case (lvl)
      2'd0:    n = 4'd10;
      2'd1:    n = 4'd7;
      2'd2:    n = 4'd5;
      default: n = 4'd3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mw_tick_gen.sv
// mw_tick_gen: divides the board clock down to a one-cycle tick
// every TICK_DIV cycles, with a synchronous restart.
module mw_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microwave_timer.sv
// microwave_timer: countdown controller with presets, door interlock,
// auto-off and beep. MICROWAVE_POWER_LEVEL_EN adds heater duty cycling.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TIME_W      = 9,
  parameter int MAX_TIME    = 320,
  parameter int STEP        = 5,
  parameter int NUM_PRESETS = 4,
  parameter logic [NUM_PRESETS*TIME_W-1:0] PRESET_TIMES = DEF_PRESETS,
  parameter int TICK_DIV    = 50_000_000,
  parameter int AUTO_OFF_S  = 30,
  parameter int BEEP_S      = 3
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   power_btn,
  input  logic                   start_btn,
  input  logic                   door_closed,
  input  logic [NUM_PRESETS-1:0] preset_req,
  input  logic                   clear_btn,
  input  logic                   inc_btn,
  input  logic                   dec_btn,
  input  logic [1:0]             power_level,
  output logic [TIME_W-1:0]      time_left,
  output logic [2:0]             state_o,
  output logic                   heater_on,
  output logic                   lamp_on,
  output logic [1:0]             turntable_phase,
  output logic                   beep,
  output logic                   display_en
);

  localparam int NB = NUM_PRESETS + 5;
  localparam int IW = $clog2(AUTO_OFF_S + 1);
  localparam int BW = $clog2(BEEP_S + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_OFF_S - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_S - 1);
  localparam logic [TIME_W:0] STEP_W = (TIME_W+1)'(STEP);
  localparam logic [TIME_W:0] MAX_W  = (TIME_W+1)'(MAX_TIME);

  state_e state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d, pre_val, inc_val, dec_val;
  logic [TIME_W:0] sum;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0] phase_q, phase_d;
  logic [NB-1:0] btn, btn_q, edge_w;
  logic [NUM_PRESETS-1:0] pre_e;
  logic pwr_e, start_e, clr_e, inc_e, dec_e;
  logic tick, tick_clr, heat_d;
  logic heater_q, lamp_q, disp_q, beep_q;

  assign btn = {preset_req, dec_btn, inc_btn,
                clear_btn, start_btn, power_btn};
  assign edge_w  = btn & ~btn_q;
  assign pwr_e   = edge_w[0];
  assign start_e = edge_w[1];
  assign clr_e   = edge_w[2];
  assign inc_e   = edge_w[3];
  assign dec_e   = edge_w[4];
  assign pre_e   = edge_w[NB-1:5];

  assign tick_clr = (state_d == ST_RUN) && (state_q != ST_RUN);

  mw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign sum     = {1'b0, time_q} + STEP_W;
  assign inc_val = (sum > MAX_W) ? MAX_W[TIME_W-1:0]
                                 : sum[TIME_W-1:0];
  assign dec_val = (time_q > STEP_W[TIME_W-1:0])
                   ? time_q - STEP_W[TIME_W-1:0] : '0;

  // Descending scan so the lowest pressed index wins.
  always_comb begin
    pre_val = '0;
    for (int i = NUM_PRESETS - 1; i >= 0; i--)
      if (pre_e[i]) pre_val = PRESET_TIMES[i*TIME_W +: TIME_W];
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    idle_d  = '0;
    bcnt_d  = '0;
    phase_d = phase_q;
    unique case (state_q)
      ST_OFF: begin
        time_d = '0;
        if (pwr_e) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        idle_d = idle_q;
        if (clr_e) time_d = '0;
        else if (|pre_e) begin
          if (time_q == '0) time_d = pre_val;
        end
        else if (inc_e) time_d = inc_val;
        else if (dec_e) time_d = dec_val;
        if (|edge_w || !door_closed) idle_d = '0;
        else if (tick) begin
          if (idle_q == IDLE_LAST) begin
            state_d = ST_OFF;
            time_d  = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
        if (start_e && door_closed && time_q != '0)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!door_closed || start_e) state_d = ST_PAUSE;
        else if (tick) begin
          phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
          if (time_q <= TIME_W'(1)) begin
            time_d  = '0;
            state_d = ST_DONE;
          end else begin
            time_d = time_q - TIME_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (clr_e) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (start_e && door_closed) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        bcnt_d = bcnt_q;
        if (start_e || !door_closed) state_d = ST_IDLE;
        else if (tick) begin
          if (bcnt_q == BEEP_LAST) state_d = ST_IDLE;
          else bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Power overrides everything else.
    if (pwr_e && state_q != ST_OFF) begin
      state_d = ST_OFF;
      time_d  = '0;
    end
  end

`ifdef MICROWAVE_POWER_LEVEL_EN
  logic [3:0] duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (tick_clr) duty_d = '0;
    else if (state_q == ST_RUN && tick)
      duty_d = (duty_q == 4'(DUTY_WIN - 1)) ? '0 : duty_q + 4'd1;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) duty_q <= '0;
    else          duty_q <= duty_d;
  end

  assign heat_d = (state_q == ST_RUN) &&
                  (duty_q < duty_ticks(power_level));
`else
  logic unused_pl;
  assign unused_pl = ^power_level;
  assign heat_d = (state_q == ST_RUN);
`endif

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_OFF;
      time_q   <= '0;
      idle_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= '0;
      btn_q    <= '0;
      heater_q <= 1'b0;
      lamp_q   <= 1'b0;
      disp_q   <= 1'b0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      idle_q   <= idle_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      btn_q    <= btn;
      heater_q <= heat_d;
      lamp_q   <= (state_q != ST_OFF) &&
                  (state_q == ST_RUN || !door_closed);
      disp_q   <= (state_q != ST_OFF);
      beep_q   <= (state_q == ST_DONE);
    end
  end

  assign time_left       = time_q;
  assign state_o         = state_q;
  assign turntable_phase = phase_q;
  assign heater_on       = heater_q;
  assign lamp_on         = lamp_q;
  assign display_en      = disp_q;
  assign beep            = beep_q;

endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed and randomized checks of microwave_timer
// against a seconds-level behavioural model, TICK_DIV = 4.
module tb_microwave_timer;

  localparam int TD = 4;
  localparam logic [35:0] PT = {9'd3, 9'd100, 9'd110, 9'd90};

  int ptab [4] = '{90, 110, 100, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic power_btn = 0, start_btn = 0, door_closed = 1;
  logic [3:0] preset_req = '0;
  logic clear_btn = 0, inc_btn = 0, dec_btn = 0;
  logic [1:0] power_level = '0;
  logic [8:0] time_left;
  logic [2:0] state_o;
  logic heater_on, lamp_on, beep, display_en;
  logic [1:0] turntable_phase;

  int errors = 0;
  int checks = 0;
  int mt;

  always #5 clk = ~clk;

  microwave_timer #(
    .PRESET_TIMES (PT),
    .TICK_DIV     (TD)
  ) dut (
    .clock_in        (clk),
    .reset_n         (rst_n),
    .power_btn       (power_btn),
    .start_btn       (start_btn),
    .door_closed     (door_closed),
    .preset_req      (preset_req),
    .clear_btn       (clear_btn),
    .inc_btn         (inc_btn),
    .dec_btn         (dec_btn),
    .power_level     (power_level),
    .time_left       (time_left),
    .state_o         (state_o),
    .heater_on       (heater_on),
    .lamp_on         (lamp_on),
    .turntable_phase (turntable_phase),
    .beep            (beep),
    .display_en      (display_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: power_btn = v;
      1: start_btn = v;
      2: clear_btn = v;
      3: inc_btn   = v;
      4: dec_btn   = v;
      default: ;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(2);
    set_btn(b, 1'b0);
    cyc(1);
  endtask

  task automatic press_preset(input logic [3:0] m);
    preset_req = m;
    cyc(2);
    preset_req = '0;
    cyc(1);
  endtask

  function automatic int m_inc(input int t);
    return (t + 5 > 320) ? 320 : t + 5;
  endfunction

  function automatic int m_dec(input int t);
    return (t < 5) ? 0 : t - 5;
  endfunction

  function automatic int m_preset(input int t, input logic [3:0] m);
    if (t != 0) return t;
    for (int i = 0; i < 4; i++)
      if (m[i]) return ptab[i];
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, k, n, p0, bc;
    logic [3:0] m;

    #1 rst_n = 1'b0;
    cyc(2);
    chk("rst_state", state_o, 0);
    chk("rst_time", time_left, 0);
    chk("rst_outs", {heater_on, lamp_on, beep, display_en}, 0);
    chk("rst_phase", turntable_phase, 0);
    rst_n = 1'b1;
    cyc(2);

    press(0);
    chk("pwr_on_state", state_o, 1);
    chk("pwr_on_disp", display_en, 1);
    mt = 0;
    press_preset(4'b0001);
    mt = m_preset(mt, 4'b0001);
    chk("preset0", time_left, mt);
    press_preset(4'b0010);
    mt = m_preset(mt, 4'b0010);
    chk("preset_blocked", time_left, mt);

    press(2);
    mt = 0;
    repeat (70) begin
      press(3);
      mt = m_inc(mt);
    end
    chk("inc_sat", time_left, mt);
    press(2);
    press(3);
    mt = 5;
    press(4);
    press(4);
    mt = 0;
    chk("dec_floor", time_left, mt);

    repeat (40) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin press(2); mt = 0; end
        1: begin
          m = 4'($urandom_range(1, 15));
          press_preset(m);
          mt = m_preset(mt, m);
        end
        2: begin press(3); mt = m_inc(mt); end
        default: begin press(4); mt = m_dec(mt); end
      endcase
      chk("rand_edit", time_left, mt);
    end

    // 3-second countdown, DONE and beep length.
    press(2);
    press_preset(4'b1000);
    chk("load3", time_left, 3);
    p0 = turntable_phase;
    start_btn = 1;
    cyc(1);
    chk("run_state", state_o, 2);
    start_btn = 0;
    cyc(1);
    chk("run_heater", heater_on, 1);
    cyc(2);
    chk("pre_tick1", time_left, 3);
    cyc(1);
    chk("tick1", time_left, 2);
    chk("phase1", turntable_phase, (p0 + 1) % 3);
    cyc(4);
    chk("tick2", time_left, 1);
    cyc(4);
    chk("tick3", time_left, 0);
    chk("done_state", state_o, 4);
    bc = 0;
    repeat (40) begin
      cyc(1);
      if (beep) bc++;
    end
    chk("beep_len", bc, 3 * TD);
    chk("after_done", state_o, 1);

    // Door interlock pause and resume.
    press(2);
    repeat (8) press(3);
    chk("load40", time_left, 40);
    start_btn = 1;
    cyc(1);
    chk("run2", state_o, 2);
    start_btn = 0;
    door_closed = 0;
    cyc(1);
    chk("pause_state", state_o, 3);
    cyc(1);
    chk("pause_heater", heater_on, 0);
    chk("pause_lamp", lamp_on, 1);
    cyc(20);
    chk("pause_hold", time_left, 40);
    door_closed = 1;
    cyc(1);
    start_btn = 1;
    cyc(1);
    chk("resume_state", state_o, 2);
    chk("resume_time", time_left, 40);
    start_btn = 0;
    cyc(3);
    chk("resume_hold", time_left, 40);
    cyc(1);
    chk("resume_tick", time_left, 39);

    // Power and start together in RUN.
    power_btn = 1;
    start_btn = 1;
    cyc(1);
    chk("pwr_start_off", state_o, 0);
    power_btn = 0;
    start_btn = 0;
    cyc(2);
    chk("off_time", time_left, 0);
    chk("off_outs", {heater_on, lamp_on, display_en}, 0);

    // Async reset mid-run.
    press(0);
    press(3);
    press(3);
    press(1);
    cyc(5);
    chk("run3", state_o, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_time", time_left, 0);
    chk("arst_outs", {heater_on, lamp_on, beep, display_en}, 0);
    chk("arst_phase", turntable_phase, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Randomized countdown lengths.
    press(0);
    repeat (3) begin
      press(2);
      k = $urandom_range(1, 3);
      repeat (k) press(3);
      mt = 5 * k;
      p0 = turntable_phase;
      start_btn = 1;
      cyc(1);
      start_btn = 0;
      n = 0;
      while (state_o != 3'd4 && n < 4 * mt + 20) begin
        cyc(1);
        n++;
      end
      chk("cd_cycles", n, 4 * mt);
      chk("cd_phase", turntable_phase, (p0 + mt) % 3);
      press(1);
      chk("beep_abort", state_o, 1);
    end

    // Auto power-off, restarted by a button edge.
    inc_btn = 1;
    cyc(1);
    inc_btn = 0;
    cyc(111);
    chk("autooff_not_yet", state_o, 1);
    inc_btn = 1;
    n = 0;
    while (state_o != 3'd0 && n < 140) begin
      cyc(1);
      n++;
      if (n == 1) inc_btn = 0;
    end
    chk("autooff_window", (n >= 118 && n <= 121), 1);
    chk("autooff_time", time_left, 0);
    cyc(2);
    chk("autooff_disp", display_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
